// File: rtl/ym_dbg_pkg.sv
// rtl/ym_dbg_pkg.sv - shared state encoding and sizing helpers for the debug chain cells
package ym_dbg_pkg;

    localparam logic YM_DBG_IDLE  = 1'b0;
    localparam logic YM_DBG_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = YM_DBG_IDLE,
        ST_SHIFT = YM_DBG_SHIFT
    } ym_dbg_state_t;

    // Counter must hold the value W itself, hence W+1 states.
    function automatic int ym_dbg_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ym_dbg_write_if.sv
// rtl/ym_dbg_write_if.sv - serial capture / word handshake bundle for ym_dbg_write
interface ym_dbg_write_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  c1;
    logic                  c2;
    logic                  start;
    logic                  ser_in;
    logic                  ack;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  overrun;
    logic                  busy;

    modport master (
        output c1, c2, start, ser_in, ack,
        input  data_out, valid, overrun, busy
    );

    modport slave (
        input  c1, c2, start, ser_in, ack,
        output data_out, valid, overrun, busy
    );
endinterface

// File: rtl/ym_dbg_deser_cnt.sv
// rtl/ym_dbg_deser_cnt.sv - frame bit counter with restart, increment and terminal count
module ym_dbg_deser_cnt
    import ym_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic MCLK,
    input  logic reset,
    input  logic restart,
    input  logic incr,
    output logic tc
);
    localparam int            CW   = ym_dbg_cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TERM = CW'(DATA_WIDTH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_step;

    // tc flags the commit that brings the count to W; the counter wraps to 0 there.
    always_comb begin
        cnt_step = restart ? ONE : (cnt + ONE);
        tc       = (restart || incr) && (cnt_step == TERM);
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || incr) begin
            cnt <= (cnt_step == TERM) ? '0 : cnt_step;
        end
    end

endmodule

// File: rtl/ym_dbg_write.sv
// rtl/ym_dbg_write.sv - debug chain tail: frames LSB-first serial bits into words with valid/ack
module ym_dbg_write
    import ym_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          MCLK,
    input  logic          reset,
    ym_dbg_write_if.slave bus
);
    ym_dbg_state_t         state;
    ym_dbg_state_t         state_next;
    logic                  stage_bit;
    logic                  stage_start;
    logic                  do_shift;
    logic                  restart;
    logic                  incr;
    logic                  tc;
    logic [DATA_WIDTH-1:0] shift_word;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  overrun_q;

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            stage_bit   <= 1'b0;
            stage_start <= 1'b0;
        end else if (bus.c1) begin
            stage_bit   <= bus.ser_in;
            stage_start <= bus.start;
        end
    end

    // shift_word is the register contents after this commit; bit 0 of the
    // stored shreg would be shifted out next, so only the upper bits are kept.
    generate
        if (DATA_WIDTH == 1) begin : g_w1
            assign shift_word = stage_bit;
        end else begin : g_wn
            logic [DATA_WIDTH-1:1] shreg;
            assign shift_word = {stage_bit, shreg[DATA_WIDTH-1:1]};
            always_ff @(posedge MCLK or negedge reset) begin
                if (!reset) begin
                    shreg <= '0;
                end else if (do_shift) begin
                    shreg <= shift_word[DATA_WIDTH-1:1];
                end
            end
        end
    endgenerate

    ym_dbg_deser_cnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cnt (
        .MCLK    (MCLK),
        .reset   (reset),
        .restart (restart),
        .incr    (incr),
        .tc      (tc)
    );

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        restart    = 1'b0;
        incr       = 1'b0;
        if (bus.c2) begin
            if (stage_start) begin
                restart    = 1'b1;
                do_shift   = 1'b1;
                state_next = ST_SHIFT;
            end else if (state == ST_SHIFT) begin
                incr     = 1'b1;
                do_shift = 1'b1;
            end
            if (tc) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (tc) begin
            if (!valid_q || bus.ack) begin
                data_q  <= shift_word;
                valid_q <= 1'b1;
                if (valid_q) begin
                    overrun_q <= 1'b0;
                end
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (bus.ack && valid_q) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = (state == ST_SHIFT);

endmodule

// File: tb/tb_ym_dbg_write.sv
// tb/tb_ym_dbg_write.sv - self-checking bench for ym_dbg_write at W=8 and W=1
module tb_ym_dbg_write;

    logic MCLK;
    logic reset;
    int   n_checks;
    int   n_err;

    ym_dbg_write_if #(.DATA_WIDTH(8)) bus8 ();
    ym_dbg_write_if #(.DATA_WIDTH(1)) bus1 ();

    ym_dbg_write #(.DATA_WIDTH(8)) dut8 (.MCLK(MCLK), .reset(reset), .bus(bus8));
    ym_dbg_write #(.DATA_WIDTH(1)) dut1 (.MCLK(MCLK), .reset(reset), .bus(bus1));

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Reference: index 0 models W=8, index 1 models W=1.
    logic [7:0] m_word  [2];
    logic [7:0] m_data  [2];
    bit         m_valid [2];
    bit         m_over  [2];
    bit         m_inf   [2];
    int         m_cnt   [2];
    bit         m_sb    [2];
    bit         m_ss    [2];

    function automatic int mw(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_word[i] = 8'h00; m_data[i] = 8'h00; m_valid[i] = 0; m_over[i] = 0;
            m_inf[i] = 0; m_cnt[i] = 0; m_sb[i] = 0; m_ss[i] = 0;
        end
    endtask

    task automatic model_edge(input bit c1, input bit c2, input bit st, input bit ser, input bit ak);
        for (int i = 0; i < 2; i++) begin
            bit comp;
            bit v0;
            comp = 0;
            v0   = m_valid[i];
            if (c2) begin
                if (m_ss[i]) begin
                    m_cnt[i] = 0;
                    m_inf[i] = 1;
                end
                if (m_inf[i]) begin
                    m_word[i][m_cnt[i]] = m_sb[i];
                    m_cnt[i]++;
                    if (m_cnt[i] == mw(i)) begin
                        comp     = 1;
                        m_inf[i] = 0;
                        m_cnt[i] = 0;
                    end
                end
            end
            if (comp) begin
                if (!v0 || ak) begin
                    m_data[i]  = m_word[i];
                    m_valid[i] = 1;
                    if (v0 && ak) m_over[i] = 0;
                end else begin
                    m_over[i] = 1;
                end
            end else if (ak && v0) begin
                m_valid[i] = 0;
                m_over[i]  = 0;
            end
            if (c1) begin
                m_sb[i] = ser;
                m_ss[i] = st;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/w8.data"},    bus8.data_out,              m_data[0]);
        chk({tag, "/w8.valid"},   {7'd0, bus8.valid},         {7'd0, m_valid[0]});
        chk({tag, "/w8.overrun"}, {7'd0, bus8.overrun},       {7'd0, m_over[0]});
        chk({tag, "/w8.busy"},    {7'd0, bus8.busy},          {7'd0, m_inf[0]});
        chk({tag, "/w1.data"},    {7'd0, bus1.data_out},      m_data[1]);
        chk({tag, "/w1.valid"},   {7'd0, bus1.valid},         {7'd0, m_valid[1]});
        chk({tag, "/w1.overrun"}, {7'd0, bus1.overrun},       {7'd0, m_over[1]});
        chk({tag, "/w1.busy"},    {7'd0, bus1.busy},          {7'd0, m_inf[1]});
    endtask

    task automatic step(input string tag, input bit c1, input bit c2, input bit st, input bit ser, input bit ak);
        @(negedge MCLK);
        bus8.c1 = c1; bus8.c2 = c2; bus8.start = st; bus8.ser_in = ser; bus8.ack = ak;
        bus1.c1 = c1; bus1.c2 = c2; bus1.start = st; bus1.ser_in = ser; bus1.ack = ak;
        @(posedge MCLK);
        model_edge(c1, c2, st, ser, ak);
        #1;
        check_all(tag);
    endtask

    task automatic pair(input string tag, input bit b, input bit st, input bit ak);
        step(tag, 1'b1, 1'b0, st, b, 1'b0);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, ak);
    endtask

    // Sends a full W=8 frame LSB first; ack_last raises ack on the completion edge.
    task automatic frame(input string tag, input logic [7:0] w, input bit ack_last);
        for (int i = 0; i < 8; i++) begin
            pair(tag, w[i], (i == 0), ack_last && (i == 7));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge MCLK);
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, "/w8.zero"}, bus8.data_out, 8'h00);
        @(negedge MCLK);
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;
        bus8.c1 = 0; bus8.c2 = 0; bus8.start = 0; bus8.ser_in = 0; bus8.ack = 0;
        bus1.c1 = 0; bus1.c2 = 0; bus1.start = 0; bus1.ser_in = 0; bus1.ack = 0;
        model_reset();
        do_reset("reset");

        frame("a5", 8'hA5, 1'b0);
        chk("a5.const", bus8.data_out, 8'hA5);
        chk("w1.const", {7'd0, bus1.data_out}, 8'h01);

        frame("3c", 8'h3C, 1'b0);
        chk("3c.hold", bus8.data_out, 8'hA5);
        chk("3c.over", {7'd0, bus8.overrun}, 8'h01);
        step("ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack.valid", {7'd0, bus8.valid}, 8'h00);

        frame("a5b", 8'hA5, 1'b0);
        frame("5a", 8'h5A, 1'b1);
        chk("5a.const", bus8.data_out, 8'h5A);
        chk("5a.over", {7'd0, bus8.overrun}, 8'h00);

        step("ack2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pair("part", 1'b0, (i == 0), 1'b0);
        frame("ff", 8'hFF, 1'b0);
        chk("ff.const", bus8.data_out, 8'hFF);

        step("ack3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pair("pre_rst", 1'b1, (i == 0), 1'b0);
        do_reset("mid_rst");
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        frame("01", 8'h01, 1'b0);
        chk("01.const", bus8.data_out, 8'h01);

        // Random traffic, including c1/c2 coincident edges and back-to-back starts.
        for (int n = 0; n < 3000; n++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
